// File: rtl/ofmap_pkg.sv
// Shared constants, packet layout and FSM encoding for the output feature-map collector.
package ofmap_pkg;

    localparam int unsigned PKT_W     = 53;
    localparam int unsigned OFMAP_DIM = 21;
    localparam int unsigned NUM_TS    = 2;
    localparam int unsigned SRC_W     = 4;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned CNT_W     = $clog2(OFMAP_DIM + 1);

    // Packet field offsets
    localparam int unsigned SRC_MSB = 52;
    localparam int unsigned SRC_LSB = 49;
    localparam int unsigned TS_BIT  = 48;
    localparam int unsigned ROW_MSB = 47;
    localparam int unsigned ROW_LSB = 43;
    localparam int unsigned SPK_MSB = 42;
    localparam int unsigned SPK_LSB = 22;

    // The collector's own mesh node; packets claiming it as source are malformed
    localparam logic [SRC_W-1:0] OUT_NODE = SRC_W'(3);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Decoded packet fields held in the intake register
    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic                 ts;
        logic [ROW_W-1:0]     row;
        logic [OFMAP_DIM-1:0] spikes;
    } entry_t;

endpackage

// File: rtl/ofmap_collector_if.sv
// Packet handshake from the mesh output port into the collector.
interface ofmap_collector_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [ofmap_pkg::PKT_W-1:0] in_pkt;

    modport master (output in_valid, output in_pkt, input in_ready);
    modport slave  (input in_valid, input in_pkt, output in_ready);

endinterface

// File: rtl/ofmap_bank.sv
// NUM_TS x OFMAP_DIM spike-row storage with one write port and a registered read port.
module ofmap_bank
    import ofmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_ts,
    input  logic [ROW_W-1:0]     wr_row,
    input  logic [OFMAP_DIM-1:0] wr_data,
    input  logic                 rd_en,
    input  logic                 rd_ts,
    input  logic [ROW_W-1:0]     rd_row,
    output logic [OFMAP_DIM-1:0] rd_data,
    output logic                 rd_valid
);

    logic [OFMAP_DIM-1:0] mem [NUM_TS][OFMAP_DIM];

    // Array write; contents survive clear and reset, only the bookkeeping is reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ts][wr_row] <= wr_data;
        end
    end

    // Registered read; same-address write in the same cycle yields the old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= (rd_row < ROW_W'(OFMAP_DIM)) ? mem[rd_ts][rd_row] : '0;
            end
        end
    end

endmodule

// File: rtl/ofmap_collector.sv
// Output-memory stage: accepts spike-row packets, stores them per timestep, tracks completion.
module ofmap_collector
    import ofmap_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    ofmap_collector_if.slave     in_if,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic                 rd_ts,
    input  logic [ROW_W-1:0]     rd_row,
    output logic [OFMAP_DIM-1:0] rd_data,
    output logic                 rd_valid,
    output logic [NUM_TS-1:0]    ts_done,
    output logic                 all_done,
    output logic                 err_range,
    output logic                 err_dup
);

    state_t                          state_q, state_d;
    logic                            in_ready_q, in_ready_d;
    entry_t                          in_entry, pkt_q;
    logic                            pkt_q_v;
    logic                            accept;
    logic                            range_bad, is_dup, do_write;
    logic [NUM_TS-1:0][OFMAP_DIM-1:0] row_valid;
    logic [NUM_TS-1:0][CNT_W-1:0]    row_cnt;
    logic [NUM_TS-1:0]               ts_done_nxt;
    logic                            unused_pkt_bits;

    assign in_if.in_ready  = in_ready_q;
    assign unused_pkt_bits = ^in_if.in_pkt[SPK_LSB-1:0];

    // Field extraction from the raw packet
    always_comb begin
        in_entry.src    = in_if.in_pkt[SRC_MSB:SRC_LSB];
        in_entry.ts     = in_if.in_pkt[TS_BIT];
        in_entry.row    = in_if.in_pkt[ROW_MSB:ROW_LSB];
        in_entry.spikes = in_if.in_pkt[SPK_MSB:SPK_LSB];
    end

    // A packet offered alongside clr is discarded with the rest of the clear
    assign accept = in_if.in_valid && in_ready_q && !clr;

    // Intake register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q   <= '0;
            pkt_q_v <= 1'b0;
        end else begin
            pkt_q_v <= accept;
            if (accept) begin
                pkt_q <= in_entry;
            end
        end
    end

    // Write-stage classification of the held packet
    always_comb begin
        range_bad = (pkt_q.row >= ROW_W'(OFMAP_DIM)) || (pkt_q.src == OUT_NODE);
        is_dup    = !range_bad && row_valid[pkt_q.ts][pkt_q.row];
        do_write  = pkt_q_v && !clr && !range_bad && !is_dup;
    end

    // Completion condition from the current row counts
    always_comb begin
        ts_done_nxt = '0;
        for (int t = 0; t < NUM_TS; t++) begin
            ts_done_nxt[t] = (row_cnt[t] == CNT_W'(OFMAP_DIM));
        end
    end

    // Row bookkeeping, completion and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid <= '0;
            row_cnt   <= '0;
            ts_done   <= '0;
            all_done  <= 1'b0;
            err_range <= 1'b0;
            err_dup   <= 1'b0;
        end else if (clr) begin
            row_valid <= '0;
            row_cnt   <= '0;
            ts_done   <= '0;
            all_done  <= 1'b0;
            err_range <= 1'b0;
            err_dup   <= 1'b0;
        end else begin
            ts_done  <= ts_done_nxt;
            all_done <= &ts_done_nxt;
            if (pkt_q_v) begin
                if (range_bad) begin
                    err_range <= 1'b1;
                end else if (is_dup) begin
                    err_dup <= 1'b1;
                end else begin
                    row_valid[pkt_q.ts][pkt_q.row] <= 1'b1;
                    row_cnt[pkt_q.ts]              <= row_cnt[pkt_q.ts] + CNT_W'(1);
                end
            end
        end
    end

    // FSM state and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (all_done && !clr) state_d = FULL;
            FULL:    if (clr)              state_d = COLLECT;
            default:                       state_d = COLLECT;
        endcase
    end

    // FSM output: intake drains every cycle, so only FULL and clr block it
    always_comb begin
        in_ready_d = 1'b0;
        if (state_d == COLLECT && !clr) begin
            in_ready_d = 1'b1;
        end
    end

    ofmap_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (do_write),
        .wr_ts    (pkt_q.ts),
        .wr_row   (pkt_q.row),
        .wr_data  (pkt_q.spikes),
        .rd_en    (rd_en),
        .rd_ts    (rd_ts),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_ofmap_collector.sv
// Scoreboard bench for ofmap_collector: model of row bookkeeping plus a read-data queue.
module tb_ofmap_collector;
    import ofmap_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 rd_en = 1'b0;
    logic                 rd_ts = 1'b0;
    logic [ROW_W-1:0]     rd_row = '0;
    logic [OFMAP_DIM-1:0] rd_data;
    logic                 rd_valid;
    logic [NUM_TS-1:0]    ts_done;
    logic                 all_done;
    logic                 err_range;
    logic                 err_dup;

    ofmap_collector_if bus ();

    ofmap_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_if     (bus),
        .clr       (clr),
        .rd_en     (rd_en),
        .rd_ts     (rd_ts),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ts_done   (ts_done),
        .all_done  (all_done),
        .err_range (err_range),
        .err_dup   (err_dup)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int stalls = 0;

    logic [OFMAP_DIM-1:0] exp_q[$];
    logic [OFMAP_DIM-1:0] m_mem [NUM_TS][OFMAP_DIM];
    bit                   m_val [NUM_TS][OFMAP_DIM];
    int                   m_cnt [NUM_TS];
    bit                   m_er, m_ed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int t = 0; t < NUM_TS; t++) begin
            m_cnt[t] = 0;
            for (int r = 0; r < OFMAP_DIM; r++) m_val[t][r] = 1'b0;
        end
        m_er = 1'b0;
        m_ed = 1'b0;
    endfunction

    function automatic void apply(input logic [3:0] src, input logic ts,
                                  input logic [4:0] row, input logic [20:0] spk);
        if (int'(row) >= OFMAP_DIM || src == 4'd3) begin
            m_er = 1'b1;
        end else if (m_val[ts][row]) begin
            m_ed = 1'b1;
        end else begin
            m_val[ts][row] = 1'b1;
            m_mem[ts][row] = spk;
            m_cnt[ts]++;
        end
    endfunction

    function automatic logic [PKT_W-1:0] make_pkt(input logic [3:0] src, input logic ts,
                                                 input logic [4:0] row, input logic [20:0] spk);
        logic [21:0] junk;
        junk = 22'($urandom);
        return {src, ts, row, spk, junk};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one packet, wait (bounded) for ready, return 1ns after the accept edge
    task automatic send(input logic [3:0] src, input logic ts,
                        input logic [4:0] row, input logic [20:0] spk);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_pkt   = make_pkt(src, ts, row, spk);
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        stalls += w;
        if (w >= 50) begin
            chk("ready_timeout", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        apply(src, ts, row, spk);
    endtask

    task automatic rd(input logic ts, input logic [4:0] row, input logic [20:0] exp);
        rd_en  = 1'b1;
        rd_ts  = ts;
        rd_row = row;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
        chk("rd_valid", 32'(rd_valid), 1);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_err_range"}, 32'(err_range), 32'(m_er));
        chk({tag, "_err_dup"}, 32'(err_dup), 32'(m_ed));
    endtask

    // Read-data scoreboard
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            chk("rd_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [20:0] old_spk;
        logic [20:0] spk_a;
        bus.in_valid = 1'b0;
        bus.in_pkt   = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ts_done", 32'(ts_done), 0);
        chk("rst_all_done", 32'(all_done), 0);
        chk_flags("rst");
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Single packet, then read back
        send(4'd5, 1'b0, 5'd7, 21'h0A5A5);
        tick();
        rd(1'b0, 5'd7, 21'h0A5A5);
        chk("single_ts_done", 32'(ts_done), 0);
        chk_flags("single");

        clr_pulse();
        chk("clr1_ts_done", 32'(ts_done), 0);
        chk_flags("clr1");

        // Full ts 0 back-to-back
        stalls = 0;
        for (int r = 0; r < OFMAP_DIM; r++) send(4'(r % 3), 1'b0, 5'(r), 21'($urandom));
        chk("burst0_stalls", 32'(stalls), 0);
        tick();
        chk("burst0_ts_done_e1", 32'(ts_done), 0);
        tick();
        chk("burst0_ts_done_e2", 32'(ts_done), 32'b01);
        chk("burst0_all_done", 32'(all_done), 0);
        rd(1'b0, 5'd0, m_mem[0][0]);
        rd(1'b0, 5'd20, m_mem[0][20]);
        rd(1'b0, 5'd25, 21'h0);

        // Full ts 1 -> all_done, then FULL
        for (int r = OFMAP_DIM - 1; r >= 0; r--) send(4'd9, 1'b1, 5'(r), 21'($urandom));
        tick();
        chk("burst1_all_done_e1", 32'(all_done), 0);
        tick();
        chk("burst1_ts_done", 32'(ts_done), 32'b11);
        chk("burst1_all_done", 32'(all_done), 1);
        chk("burst1_ready_still", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_pkt   = make_pkt(4'd2, 1'b1, 5'd4, 21'h15555);
        tick();
        apply(4'd2, 1'b1, 5'd4, 21'h15555);
        bus.in_pkt = make_pkt(4'd2, 1'b0, 5'd5, 21'h0F0F0);
        for (int i = 0; i < 3; i++) begin
            chk("full_in_ready", 32'(bus.in_ready), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk_flags("full");
        rd(1'b1, 5'd4, m_mem[1][4]);
        clr_pulse();
        chk("clr2_ts_done", 32'(ts_done), 0);
        chk("clr2_all_done", 32'(all_done), 0);
        chk("clr2_in_ready", 32'(bus.in_ready), 1);
        chk_flags("clr2");

        // Same-cycle read returns pre-write data; memory survives clr
        old_spk = m_mem[0][7];
        send(4'd1, 1'b0, 5'd7, 21'h1F00F);
        rd(1'b0, 5'd7, old_spk);
        rd(1'b0, 5'd7, 21'h1F00F);

        // Range and duplicate errors leave counts untouched
        send(4'd2, 1'b1, 5'd21, 21'h12345);
        tick();
        chk_flags("range_row");
        send(4'd3, 1'b1, 5'd2, 21'h00777);
        tick();
        chk_flags("range_src");
        spk_a = 21'h0ABCD;
        send(4'd6, 1'b1, 5'd3, spk_a);
        send(4'd6, 1'b1, 5'd3, 21'h1DCBA);
        tick();
        chk_flags("dup");
        rd(1'b1, 5'd3, spk_a);
        for (int r = 0; r < OFMAP_DIM - 1; r++) begin
            if (r != 3) send(4'd0, 1'b1, 5'(r), 21'($urandom));
        end
        tick();
        tick();
        chk("partial1_ts_done", 32'(ts_done), 0);
        send(4'd0, 1'b1, 5'd20, 21'h1);
        tick();
        tick();
        chk("complete1_ts_done", 32'(ts_done), 32'b10);

        // clr while the intake register holds a valid row
        clr_pulse();
        send(4'd1, 1'b0, 5'd0, 21'h00055);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        tick();
        for (int r = 1; r < OFMAP_DIM; r++) send(4'd1, 1'b0, 5'(r), 21'($urandom));
        tick();
        tick();
        chk("clrq_ts_done_partial", 32'(ts_done), 0);
        send(4'd1, 1'b0, 5'd0, 21'h000AA);
        tick();
        tick();
        chk("clrq_ts_done", 32'(ts_done), 32'b01);
        chk_flags("clrq");

        // Reset in the middle of a burst
        for (int r = 0; r < 10; r++) send(4'd7, 1'b1, 5'(r), 21'($urandom));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
        chk("mid_rst_rd_data", 32'(rd_data), 0);
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        chk("mid_rst_ts_done", 32'(ts_done), 0);
        chk("mid_rst_all_done", 32'(all_done), 0);
        model_clear();
        exp_q.delete();
        chk_flags("mid_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < OFMAP_DIM - 1; r++) send(4'd7, 1'b1, 5'(r), 21'($urandom));
        tick();
        tick();
        chk("rerun_ts_done_partial", 32'(ts_done), 0);
        chk_flags("rerun");
        send(4'd7, 1'b1, 5'd20, 21'h2);
        tick();
        tick();
        chk("rerun_ts_done", 32'(ts_done), 32'b10);
        rd(1'b1, 5'd20, 21'h2);

        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
